// File: rtl/div_unit_pkg.sv
// div_unit_pkg: shared widths and FSM state encoding for the iterative divider
package div_unit_pkg;
  localparam int W_DATA = 32;
  localparam int CNT_W_DEF = 6;
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ITER, S_FIX, S_DONE} state_t;
endpackage

// File: rtl/div_unit_if.sv
// div_unit_if: execute-stage divide request (run/u/x/y) and response (stall/done/quot/rem)
interface div_unit_if #(parameter int W = 32);
  logic run;
  logic u;
  logic [W-1:0] x;
  logic [W-1:0] y;
  logic stall;
  logic done;
  logic [W-1:0] quot;
  logic [W-1:0] rem;
  modport master(output run, u, x, y, input stall, done, quot, rem);
  modport slave(input run, u, x, y, output stall, done, quot, rem);
endinterface

// File: rtl/div_unit_step.sv
// div_step: one combinational restoring-division step (shift in a MSB, trial subtract b)
module div_step #(parameter int W = 32) (
  input  logic [W-1:0] i_rem,
  input  logic         i_a_msb,
  input  logic [W-1:0] i_b,
  output logic [W-1:0] o_rem_next,
  output logic         o_qbit
);
  logic [W:0]   w_shift;
  logic [W+1:0] w_diff;
  assign w_shift    = {i_rem, i_a_msb};
  assign w_diff     = {1'b0, w_shift} - {2'b00, i_b};
  assign o_qbit     = ~w_diff[W+1];
  assign o_rem_next = o_qbit ? w_diff[W-1:0] : w_shift[W-1:0];
endmodule

// File: rtl/div_unit.sv
// div_unit: iterative floor divider, signed/unsigned dividend by unsigned divisor, stalls until done
module div_unit import div_unit_pkg::*; #(
  parameter int W     = W_DATA,
  parameter int CNT_W = CNT_W_DEF
) (
  input logic       clk,
  input logic       rst,
  div_unit_if.slave io_div
);
  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_sign;
  logic [W-1:0]     r_a;
  logic [W-1:0]     r_b;
  logic [W-1:0]     r_r;
  logic [W-1:0]     r_q;
  logic             r_done;
  logic [W-1:0]     r_quot;
  logic [W-1:0]     r_rem;
  logic             w_neg;
  logic [W-1:0]     w_rem_next;
  logic             w_qbit;
  logic             w_rz;
  logic [W-1:0]     w_fix_q;
  logic [W-1:0]     w_fix_r;
  div_step #(.W(W)) u_step (
    .i_rem     (r_r),
    .i_a_msb   (r_a[W-1]),
    .i_b       (r_b),
    .o_rem_next(w_rem_next),
    .o_qbit    (w_qbit)
  );
  assign w_neg = ~io_div.u & io_div.x[W-1];
  always_comb begin
    w_rz    = (r_r == '0);
    w_fix_q = !r_sign ? r_q : w_rz ? -r_q : ~r_q;
    w_fix_r = !r_sign ? r_r : w_rz ? '0 : r_b - r_r;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_sign  <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_r     <= '0;
      r_q     <= '0;
      r_done  <= 1'b0;
      r_quot  <= '0;
      r_rem   <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (io_div.run) r_state <= S_LOAD;
        S_LOAD:
          if (!io_div.run) r_state <= S_IDLE;
          else begin
            r_sign  <= w_neg;
            r_a     <= w_neg ? -io_div.x : io_div.x;
            r_b     <= io_div.y;
            r_r     <= '0;
            r_q     <= '0;
            r_cnt   <= '0;
            r_state <= S_ITER;
          end
        S_ITER:
          if (!io_div.run) r_state <= S_IDLE;
          else begin
            r_r   <= w_rem_next;
            r_q   <= {r_q[W-2:0], w_qbit};
            r_a   <= {r_a[W-2:0], 1'b0};
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == CNT_W'(W-1)) r_state <= S_FIX;
          end
        S_FIX:
          if (!io_div.run) r_state <= S_IDLE;
          else begin
            r_quot  <= w_fix_q;
            r_rem   <= w_fix_r;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end
        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
  assign io_div.stall = io_div.run & ~r_done;
  assign io_div.done  = r_done;
  assign io_div.quot  = r_quot;
  assign io_div.rem   = r_rem;
endmodule
